mgr_stack_down_arbiter: RTL

- Shares one downstream stack-bus channel among the NUM_MGR managers instantiated in the manager array.
- Each manager presents packets of beats with valid/ready handshakes. The arbiter grants one manager at a time, round-robin, and holds the grant for the whole packet.
- Beats are forwarded through a single registered output stage, tagged with the source manager ID.
- Sits between the manager array's per-manager downstream ports and the system stack-bus downstream interface.

---
 rtl/mgr_stack_down_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mgr_stack_down_arbiter.sv
// rtl/mgr_stack_down_arbiter.sv - round-robin packet arbiter onto the downstream stack bus
module mgr_stack_down_arbiter #(
  parameter int NUM_MGR  = 4,
  parameter int MGR_ID_W = 2,
  parameter int DATA_W   = 64,
  parameter int OOB_W    = 32,
  parameter int TYPE_W   = 2
) (
  input  logic                        clk,
  input  logic                        reset_poweron,
  input  logic [NUM_MGR-1:0]          mgr__arb__valid,
  input  logic [2*NUM_MGR-1:0]        mgr__arb__cntl,
  input  logic [TYPE_W*NUM_MGR-1:0]   mgr__arb__type,
  input  logic [DATA_W*NUM_MGR-1:0]   mgr__arb__data,
  input  logic [OOB_W*NUM_MGR-1:0]    mgr__arb__oob_data,
  output logic [NUM_MGR-1:0]          arb__mgr__ready,
  output logic                        arb__std__valid,
  output logic [1:0]                  arb__std__cntl,
  output logic [TYPE_W-1:0]           arb__std__type,
  output logic [DATA_W-1:0]           arb__std__data,
  output logic [OOB_W-1:0]            arb__std__oob_data,
  output logic [MGR_ID_W-1:0]         arb__std__mgrId,
  input  logic                        std__arb__ready,
  output logic                        arb__sys__busy,
  output logic                        arb__sys__protocolErr,
  output logic [15:0]                 arb__sys__pktCount
);

  localparam logic [1:0] C_SOM_EOM = 2'b00;
  localparam logic [1:0] C_SOM     = 2'b01;
  localparam logic [1:0] C_MOM     = 2'b10;
  localparam logic [1:0] C_EOM     = 2'b11;

  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t                r_state;
  logic [MGR_ID_W-1:0]   r_last;
  logic [MGR_ID_W-1:0]   r_owner;
  logic                  r_valid;
  logic [1:0]            r_cntl;
  logic [TYPE_W-1:0]     r_type;
  logic [DATA_W-1:0]     r_data;
  logic [OOB_W-1:0]      r_oob;
  logic [MGR_ID_W-1:0]   r_mgr_id;
  logic                  r_proto_err;
  logic [15:0]           r_pkt_count;

  logic [MGR_ID_W-1:0]   w_sel;
  logic                  w_found;
  logic                  w_grant_valid;
  logic                  w_owner_valid;
  logic                  w_out_free;
  logic                  w_xfer;
  logic                  w_end;
  logic [1:0]            w_sel_cntl;
  logic [TYPE_W-1:0]     w_sel_type;
  logic [DATA_W-1:0]     w_sel_data;
  logic [OOB_W-1:0]      w_sel_oob;

  // Pick the granted manager: the packet owner while a packet is open, else round-robin after r_last
  always_comb begin
    w_sel         = '0;
    w_found       = 1'b0;
    w_grant_valid = 1'b0;
    w_owner_valid = 1'b0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (MGR_ID_W'(i) == r_owner) w_owner_valid = mgr__arb__valid[i];
    end
    if (r_state == S_PKT) begin
      w_sel         = r_owner;
      w_grant_valid = w_owner_valid;
    end else begin
      // first pass covers indices above the last winner, second pass wraps to the bottom
      for (int i = 0; i < NUM_MGR; i++) begin
        if (!w_found && mgr__arb__valid[i] && (MGR_ID_W'(i) > r_last)) begin
          w_found = 1'b1;
          w_sel   = MGR_ID_W'(i);
        end
      end
      for (int i = 0; i < NUM_MGR; i++) begin
        if (!w_found && mgr__arb__valid[i]) begin
          w_found = 1'b1;
          w_sel   = MGR_ID_W'(i);
        end
      end
      w_grant_valid = |mgr__arb__valid;
    end
  end

  // Route the selected manager's beat fields to the output stage input
  always_comb begin
    w_sel_cntl = '0;
    w_sel_type = '0;
    w_sel_data = '0;
    w_sel_oob  = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (MGR_ID_W'(i) == w_sel) begin
        w_sel_cntl = mgr__arb__cntl[2*i +: 2];
        w_sel_type = mgr__arb__type[TYPE_W*i +: TYPE_W];
        w_sel_data = mgr__arb__data[DATA_W*i +: DATA_W];
        w_sel_oob  = mgr__arb__oob_data[OOB_W*i +: OOB_W];
      end
    end
  end

  // The stage can take a beat when empty or when its beat leaves this cycle; reset blocks all transfers
  assign w_out_free = ~r_valid | std__arb__ready;
  assign w_xfer     = w_grant_valid & w_out_free & ~reset_poweron;
  assign w_end      = (w_sel_cntl == C_SOM_EOM) | (w_sel_cntl == C_EOM);

  // Ready only to the selected manager, so unselected requesters never affect their own ready
  always_comb begin
    arb__mgr__ready = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      arb__mgr__ready[i] = (MGR_ID_W'(i) == w_sel) & w_out_free & w_grant_valid & ~reset_poweron;
    end
  end

  // Packet FSM, output register, error flag and packet counter
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_state     <= S_IDLE;
      r_last      <= MGR_ID_W'(NUM_MGR - 1);
      r_owner     <= '0;
      r_valid     <= 1'b0;
      r_cntl      <= '0;
      r_type      <= '0;
      r_data      <= '0;
      r_oob       <= '0;
      r_mgr_id    <= '0;
      r_proto_err <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      if (w_out_free) begin
        r_valid <= w_xfer;
        if (w_xfer) begin
          r_cntl   <= w_sel_cntl;
          r_type   <= w_sel_type;
          r_data   <= w_sel_data;
          r_oob    <= w_sel_oob;
          r_mgr_id <= w_sel;
        end
      end
      if (w_xfer) begin
        case (r_state)
          S_IDLE: begin
            // a packet opening with MOM/EOM is flagged but still forwarded
            if (w_sel_cntl == C_MOM || w_sel_cntl == C_EOM) r_proto_err <= 1'b1;
            if (w_end) begin
              r_last      <= w_sel;
              r_pkt_count <= r_pkt_count + 16'd1;
            end else begin
              r_state <= S_PKT;
              r_owner <= w_sel;
            end
          end
          S_PKT: begin
            // a new start inside an open packet is flagged; SOM_EOM still closes it
            if (w_sel_cntl == C_SOM || w_sel_cntl == C_SOM_EOM) r_proto_err <= 1'b1;
            if (w_end) begin
              r_state     <= S_IDLE;
              r_last      <= r_owner;
              r_pkt_count <= r_pkt_count + 16'd1;
            end
          end
        endcase
      end
    end
  end

  assign arb__std__valid       = r_valid;
  assign arb__std__cntl        = r_cntl;
  assign arb__std__type        = r_type;
  assign arb__std__data        = r_data;
  assign arb__std__oob_data    = r_oob;
  assign arb__std__mgrId       = r_mgr_id;
  assign arb__sys__busy        = (r_state == S_PKT);
  assign arb__sys__protocolErr = r_proto_err;
  assign arb__sys__pktCount    = r_pkt_count;

endmodule
